// File: rtl/pong_pkg.sv
// Shared constants and helpers for the pong player-I/O block:
// LFSR feedback mask and seed, debounce length, seven-segment lookup.
package pong_pkg;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Default LFSR seed; an all-zero state would lock the LFSR up
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // 10 ms of stable input at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg7(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debounce_hex_rng_if.sv
// Player-I/O signal bundle: raw/debounced keys, RNG bound/value,
// score digits and their seven-segment patterns.
interface debounce_hex_rng_if;
  logic [3:0] key_raw;
  logic [3:0] key_db;
  logic [9:0] rng_limit;
  logic [9:0] rng_value;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;

  // Game logic side: supplies keys, bound and digits, consumes results
  modport master (
    output key_raw, rng_limit, digit0, digit1, digit2, digit3,
    input  key_db, rng_value, hex0, hex1, hex2, hex3
  );

  // Player-I/O block side
  modport slave (
    input  key_raw, rng_limit, digit0, digit1, digit2, digit3,
    output key_db, rng_value, hex0, hex1, hex2, hex3
  );
endinterface

// File: rtl/key_debouncer.sv
// Single push-button debouncer: two-flop synchronizer followed by a
// stability counter. The output only changes after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             db_reg;
  logic             db_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Synchronizer, counter and debounced state; keys idle released (1)
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      db_reg    <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      db_reg    <= db_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Count disagreeing cycles; any agreeing cycle restarts the count
  always_comb begin
    cnt_next = '0;
    db_next  = db_reg;
    if (sync2_reg != db_reg) begin
      if (cnt_reg == CNT_LAST) begin
        db_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign key_db = db_reg;

endmodule

// File: rtl/debounce_hex_rng.sv
// Player-I/O support block for pong: four key debouncers, a bounded
// pseudo-random generator for serves, and four seven-segment decoders.
module debounce_hex_rng
  import pong_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT  // must be nonzero
) (
  input  logic               CLOCK_50,
  input  logic               rst_n,
  debounce_hex_rng_if.slave  io
);

  logic [3:0]  key_db_bits;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [9:0]  rng_value_reg;
  logic [9:0]  rng_value_next;

  // One independent debouncer per key
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debouncer (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_raw  (io.key_raw[gi]),
        .key_db   (key_db_bits[gi])
      );
    end
  endgenerate

  assign io.key_db = key_db_bits;

  // Galois LFSR step and scaling of its low 10 bits into 0..rng_limit-1;
  // the scaled value is (x * limit) / 1024, so it stays below limit
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]};
    if (lfsr_reg[0]) begin
      lfsr_next = lfsr_next ^ LFSR_MASK;
    end
    rng_value_next = 10'((20'(lfsr_reg[9:0]) * 20'(io.rng_limit)) >> 10);
  end

  // LFSR free-runs every cycle; rng_value lags the LFSR by one cycle
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg      <= LFSR_SEED;
      rng_value_reg <= '0;
    end else begin
      lfsr_reg      <= lfsr_next;
      rng_value_reg <= rng_value_next;
    end
  end

  assign io.rng_value = rng_value_reg;

  // Score digits decode straight through, independent of reset
  assign io.hex0 = seg7(io.digit0);
  assign io.hex1 = seg7(io.digit1);
  assign io.hex2 = seg7(io.digit2);
  assign io.hex3 = seg7(io.digit3);

endmodule

// File: tb/tb_debounce_hex_rng.sv
// Directed bench for debounce_hex_rng with DEBOUNCE_CYCLES=16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_debounce_hex_rng;

  logic CLOCK_50;
  logic rst_n;
  int   checks;
  int   failures;

  logic [6:0] hex_exp [16];
  int         hist [8];
  int         bad_cnt;
  int         max_val;

  debounce_hex_rng_if io ();

  debounce_hex_rng #(
    .DEBOUNCE_CYCLES (16),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .io       (io)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hex_exp = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // 1. Reset with all keys pressed; outputs must show released / zero
    rst_n        = 1'b0;
    io.key_raw   = 4'b0000;
    io.rng_limit = 10'd1023;
    io.digit0    = 4'd0;
    io.digit1    = 4'd0;
    io.digit2    = 4'd0;
    io.digit3    = 4'd0;
    step(3);
    check("rst_key_db", 32'(io.key_db), 32'h0000000F);
    check("rst_rng", 32'(io.rng_value), 32'd0);

    // Release; lfsr ACE1 -> E270 -> 7138, limit 1023 gives x-1 for each
    rst_n      = 1'b1;
    io.key_raw = 4'b1111;
    step(1);
    check("rng_step1", 32'(io.rng_value), 32'd224);
    step(1);
    check("rng_step2", 32'(io.rng_value), 32'd623);
    step(1);
    check("rng_step3", 32'(io.rng_value), 32'd311);
    step(20);
    check("idle_key_db", 32'(io.key_db), 32'h0000000F);

    // 2. Clean press on key 2: falls 18 cycles after the edge
    io.key_raw = 4'b1011;
    step(17);
    check("press2_early", 32'(io.key_db), 32'h0000000F);
    step(1);
    check("press2_fall", 32'(io.key_db), 32'h0000000B);
    step(12);
    check("press2_hold", 32'(io.key_db), 32'h0000000B);
    io.key_raw = 4'b1111;
    step(17);
    check("rel2_early", 32'(io.key_db), 32'h0000000B);
    step(1);
    check("rel2_rise", 32'(io.key_db), 32'h0000000F);

    // 3. Bounce on key 0: 5-cycle segments never reach key_db
    for (int i = 0; i < 20; i++) begin
      io.key_raw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      for (int j = 0; j < 5; j++) begin
        step(1);
        check("bounce0", 32'(io.key_db), 32'h0000000F);
      end
    end
    io.key_raw = 4'b1110;
    step(17);
    check("settle0_early", 32'(io.key_db), 32'h0000000F);
    step(1);
    check("settle0_fall", 32'(io.key_db), 32'h0000000E);
    io.key_raw = 4'b1111;
    step(20);
    check("rel0", 32'(io.key_db), 32'h0000000F);

    // Simultaneous press of all four keys: same latency for each
    io.key_raw = 4'b0000;
    step(17);
    check("all_early", 32'(io.key_db), 32'h0000000F);
    step(1);
    check("all_fall", 32'(io.key_db), 32'h00000000);
    io.key_raw = 4'b1111;
    step(20);
    check("all_rel", 32'(io.key_db), 32'h0000000F);

    // 4. RNG bound 8: every value below 8, each seen often
    io.rng_limit = 10'd8;
    step(1);
    for (int k = 0; k < 8; k++) hist[k] = 0;
    bad_cnt = 0;
    for (int n = 0; n < 10000; n++) begin
      if (io.rng_value < 10'd8) hist[io.rng_value[2:0]]++;
      else bad_cnt++;
      step(1);
    end
    check("rng8_range", 32'(bad_cnt), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rng8_bin%0d_ge1000", k), 32'(hist[k] >= 1000), 32'd1);
    end

    // RNG bound 470: max stays at or below 469 and is not stuck low
    io.rng_limit = 10'd470;
    step(1);
    max_val = 0;
    for (int n = 0; n < 3000; n++) begin
      if (int'(io.rng_value) > max_val) max_val = int'(io.rng_value);
      step(1);
    end
    check("rng470_max_le", 32'(max_val <= 469), 32'd1);
    check("rng470_max_ge", 32'(max_val >= 400), 32'd1);

    // RNG bound 0: always zero
    io.rng_limit = 10'd0;
    step(1);
    bad_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      if (io.rng_value !== 10'd0) bad_cnt++;
      step(1);
    end
    check("rng0_zero", 32'(bad_cnt), 32'd0);

    // 5. Hex decode sweep and fixed digits
    for (int d = 0; d < 16; d++) begin
      io.digit0 = 4'(d);
      #1;
      check($sformatf("hex0_%0h", d), 32'(io.hex0), 32'(hex_exp[d]));
    end
    io.digit1 = 4'd9;
    io.digit2 = 4'd0;
    io.digit3 = 4'd1;
    #1;
    check("hex1_9", 32'(io.hex1), 32'h10);
    check("hex2_0", 32'(io.hex2), 32'h40);
    check("hex3_1", 32'(io.hex3), 32'h79);
    step(1);

    // 6. Async reset mid-count on key 1
    io.key_raw   = 4'b1101;
    io.rng_limit = 10'd1023;
    step(10);
    check("mid_pre", 32'(io.key_db), 32'h0000000F);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_key_db", 32'(io.key_db), 32'h0000000F);
    check("mid_rst_rng", 32'(io.rng_value), 32'd0);
    step(2);
    io.key_raw = 4'b1111;
    rst_n      = 1'b1;
    step(1);
    check("rerst_rng1", 32'(io.rng_value), 32'd224);
    step(39);
    check("mid_no_fall", 32'(io.key_db), 32'h0000000F);

    // Press again after reset: full latency, no leftover count
    io.key_raw = 4'b1101;
    step(17);
    check("post_early", 32'(io.key_db), 32'h0000000F);
    step(1);
    check("post_fall", 32'(io.key_db), 32'h0000000D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
